lcd_bus_reader: RTL

- Read-side companion to the LCD write path: performs HD44780 8-bit read cycles (lcd_rw=1) to fetch the busy flag/address counter (RS=0) or DDRAM/CGRAM data (RS=1).
- Sits beside lcd_wrapper on the clk_1MHz domain; the top-level muxes lcd_rs/lcd_rw/lcd_en and tristates lcd_db using lcd_db_oe.
- Optional busy-poll mode repeats RS=0 reads until BF=0 or a poll limit is reached, so the FSM can gate writes on real LCD readiness.

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_bus_reader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD bus types and 1 MHz timing defaults
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN    = 3'd1,
    SETUP   = 3'd2,
    EN_HIGH = 3'd3,
    HOLD    = 3'd4,
    RELEASE = 3'd5
  } lcd_state_e;

  localparam int DEF_T_SETUP   = 1;
  localparam int DEF_T_EN      = 1;
  localparam int DEF_T_HOLD    = 1;
  localparam int DEF_MAX_POLLS = 64;

  localparam int   BF_BIT  = 7;
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_bus_reader.sv
// rtl/lcd_bus_reader.sv - HD44780 8-bit read cycle engine with optional busy-flag polling
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_EN      = DEF_T_EN,
  parameter int T_HOLD    = DEF_T_HOLD,
  parameter int MAX_POLLS = DEF_MAX_POLLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       timeout,
  input  logic [7:0] lcd_db_in,
  output logic       lcd_db_oe,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int T_MAX = (T_SETUP > T_EN) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                          : ((T_EN > T_HOLD) ? T_EN : T_HOLD);
  localparam int PW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int CW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

  localparam logic [PW-1:0] LD_SETUP = PW'(T_SETUP - 1);
  localparam logic [PW-1:0] LD_EN    = PW'(T_EN - 1);
  localparam logic [PW-1:0] LD_HOLD  = PW'(T_HOLD - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_POLLS - 1);

  lcd_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic          poll_q, poll_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;
  logic          ready_q, oe_q, rw_q, en_q, lcd_rs_q;
  logic          rw_window_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    poll_d    = poll_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && ready_q) begin
          rs_d      = req_rs;
          poll_d    = req_poll && (req_rs == RS_CMD);
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = TURN;
        end
      end
      TURN: begin
        state_d = SETUP;
        phase_d = LD_SETUP;
      end
      SETUP: begin
        if (phase_q == '0) begin
          state_d = EN_HIGH;
          phase_d = LD_EN;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      EN_HIGH: begin
        if (phase_q == '0) begin
          rdata_d = lcd_db_in;
          state_d = HOLD;
          phase_d = LD_HOLD;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      HOLD: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PW'(1);
        end else if (poll_q && rdata_q[BF_BIT]) begin
          // Still busy: either poll again (RW stays high) or give up.
          if (cnt_q < CNT_LAST) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = SETUP;
            phase_d = LD_SETUP;
          end else begin
            timeout_d = 1'b1;
            state_d   = RELEASE;
          end
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rw_window_d = (state_d == SETUP) || (state_d == EN_HIGH) || (state_d == HOLD);

  // Pin outputs are decoded from the next state so they register in step with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      rdata_q   <= 8'h00;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      oe_q      <= 1'b1;
      rw_q      <= 1'b0;
      en_q      <= 1'b0;
      lcd_rs_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      ready_q   <= (state_d == IDLE);
      oe_q      <= (state_d == IDLE);
      rw_q      <= rw_window_d;
      en_q      <= (state_d == EN_HIGH);
      lcd_rs_q  <= rw_window_d ? rs_d : 1'b0;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign timeout   = timeout_q;
  assign lcd_db_oe = oe_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = rw_q;
  assign lcd_en    = en_q;

endmodule
